// File: rtl/down_sampler_n_1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : down_sampler_n_1_pkg
// Purpose  : Shared constants and types for the RX N:1 down-sampler. The
//            sample width and default decimation factor match the TX
//            zero-stuffing up-sampler so both ends stay in step.
// Contents : SAMPLE_W, DEFAULT_LOG2_FACTOR, ds_mode_e, phase_w()
// Revision : 1.0 - initial release
// ============================================================================
package down_sampler_n_1_pkg;

  localparam int SAMPLE_W            = 18;
  localparam int DEFAULT_LOG2_FACTOR = 2;

  typedef enum logic [0:0] {
    MODE_PICK = 1'b0,
    MODE_DUMP = 1'b1
  } ds_mode_e;

  // Phase registers need at least one bit even when FACTOR = 1.
  function automatic int phase_w(input int log2_factor);
    return (log2_factor > 0) ? log2_factor : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/down_sampler_n_1_sample_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_sampler_n_1_sample_phase_counter
// Purpose  : Tracks the position of each input sample within its decimation
//            block. Advances only on sam_clk; sym_clk requests re-alignment
//            so that the next strobed sample becomes phase 0.
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            sam_clk         - input-sample strobe
//            sym_clk         - symbol-alignment strobe
//            phase_o         - phase of the sample presented this cycle
//            phase0_o        - that sample starts a block
//            wrap_o          - that sample ends a block (phase FACTOR-1)
// Revision : 1.0 - initial release
// ============================================================================
module down_sampler_n_1_sample_phase_counter
  import down_sampler_n_1_pkg::*;
#(
  parameter  int LOG2_FACTOR = DEFAULT_LOG2_FACTOR,
  localparam int PW          = phase_w(LOG2_FACTOR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sam_clk,
  input  logic          sym_clk,
  output logic [PW-1:0] phase_o,
  output logic          phase0_o,
  output logic          wrap_o
);

  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << LOG2_FACTOR) - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          align_pend_q, align_pend_d;

  // A pending alignment, or one arriving in the same cycle as the strobe,
  // forces the current sample to phase 0.
  always_comb begin
    phase_o  = (align_pend_q || sym_clk) ? '0 : phase_q;
    phase0_o = (phase_o == '0);
    wrap_o   = (phase_o == LAST_PHASE);
  end

  always_comb begin
    phase_d      = phase_q;
    align_pend_d = align_pend_q;
    if (sam_clk) begin
      align_pend_d = 1'b0;
      phase_d      = wrap_o ? '0 : (phase_o + PW'(1));
    end else if (sym_clk) begin
      align_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      align_pend_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      align_pend_q <= align_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/down_sampler_n_1.sv
`default_nettype none
// ============================================================================
// Module   : down_sampler_n_1
// Purpose  : RX rate reducer. Emits one output per FACTOR strobed input
//            samples: either the sample at a selectable phase (pick) or the
//            block average rounded toward -inf (integrate-and-dump).
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            sam_clk         - input-sample strobe, x_in valid when high
//            sym_clk         - re-aligns the block phase
//            mode            - 0 pick, 1 dump; takes effect at block start
//            phase_sel       - phase kept in pick mode
//            x_in            - signed input sample
//            y, y_valid      - registered output and its 1-cycle update pulse
// Revision : 1.0 - initial release
// ============================================================================
module down_sampler_n_1
  import down_sampler_n_1_pkg::*;
#(
  parameter  int WIDTH       = SAMPLE_W,
  parameter  int LOG2_FACTOR = DEFAULT_LOG2_FACTOR,
  localparam int PW          = phase_w(LOG2_FACTOR),
  localparam int AW          = WIDTH + LOG2_FACTOR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk,
  input  logic                    sym_clk,
  input  logic                    mode,
  input  logic [PW-1:0]           phase_sel,
  input  logic signed [WIDTH-1:0] x_in,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid
);

  logic [PW-1:0] phase;
  logic          phase0;
  logic          wrap;

  down_sampler_n_1_sample_phase_counter #(
    .LOG2_FACTOR (LOG2_FACTOR)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .sam_clk  (sam_clk),
    .sym_clk  (sym_clk),
    .phase_o  (phase),
    .phase0_o (phase0),
    .wrap_o   (wrap)
  );

  ds_mode_e                mode_q, mode_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    y_valid_q, y_valid_d;

  ds_mode_e                mode_eff;
  logic                    pick_hit;
  logic signed [AW-1:0]    x_ext;
  logic signed [AW-1:0]    acc_base;
  logic signed [AW-1:0]    acc_sum;

  // With FACTOR = 1 every sample is its own block, so pick always hits.
  generate
    if (LOG2_FACTOR == 0) begin : g_pick_all
      assign pick_hit = 1'b1;
    end else begin : g_pick_cmp
      assign pick_hit = (phase == phase_sel);
    end
  endgenerate

  // The phase-0 sample already belongs to the block governed by the newly
  // sampled mode, so use the incoming value for that one sample.
  assign mode_eff = (sam_clk && phase0) ? ds_mode_e'(mode) : mode_q;

  // Phase 0 starts from zero, which also discards any partial block left
  // behind by a mid-block re-alignment.
  assign x_ext    = AW'(x_in);
  assign acc_base = phase0 ? '0 : acc_q;
  assign acc_sum  = acc_base + x_ext;

  always_comb begin
    mode_d    = mode_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (sam_clk) begin
      if (phase0) begin
        mode_d = ds_mode_e'(mode);
      end
      if (mode_eff == MODE_PICK) begin
        if (pick_hit) begin
          y_d       = x_in;
          y_valid_d = 1'b1;
        end
      end else if (wrap) begin
        // Sum of FACTOR samples fits in AW bits; the arithmetic shift
        // brings the mean back into WIDTH bits, rounding toward -inf.
        y_d       = WIDTH'(acc_sum >>> LOG2_FACTOR);
        y_valid_d = 1'b1;
        acc_d     = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_PICK;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire
